alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64, power of two.
REQ-002 Parameter MULT_EN, default 1, enables the iterative multiply; 0 makes funct 011000 illegal.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 aluop  input  2  main-decoder ALU opcode.
REQ-008 funct  input  6  R-type function field, used only when aluop=10.
REQ-009 a, b  input  WIDTH each  operands; shift amount is b[log2(WIDTH)-1:0].
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  result == 0.
REQ-014 ovf  output  1  signed overflow, add/sub only.
REQ-015 err  output  1  illegal aluop/funct combination.

Function
REQ-016 Decode: aluop 00 -> add; 01 -> sub; 11 -> illegal; 10 -> funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed), 000000 sll, 000010 srl, 000011 sra, 011000 mult; any other funct -> illegal.
REQ-017 Operands, decoded op and err SHALL be captured on the accept cycle (in_valid & in_ready); inputs are don't-care otherwise.
REQ-018 FSM states IDLE, BUSY, DONE; in_ready = (IDLE) or (DONE and out_ready); out_valid = DONE.
REQ-019 IDLE + accept of non-mult op -> DONE next cycle; result registered (latency 1).
REQ-020 IDLE + accept of mult -> BUSY; shift-add over exactly WIDTH cycles, then DONE; result = low WIDTH bits of unsigned a*b (latency WIDTH+1).
REQ-021 BUSY ignores in_valid and out_ready; in_ready = 0.
REQ-022 DONE holds result, zero, ovf, err stable until out_ready=1.
REQ-023 DONE + out_ready + in_valid: result retired and new request accepted the same cycle (back-to-back, no bubble).
REQ-024 DONE + out_ready + no in_valid -> IDLE.
REQ-025 Illegal op: completes with latency 1, result = 0, zero = 1, err = 1, ovf = 0.
REQ-026 ovf = 1 only for add/sub when operand signs and result sign satisfy the two's-complement overflow rule; wrap-around result is still returned.
REQ-027 slt returns 1 or 0 zero-extended to WIDTH; sra replicates a[WIDTH-1]; shift by 0 returns a unchanged.
REQ-028 Outputs outside DONE SHALL keep their last value; consumers rely only on out_valid.

Reset
REQ-029 rst_n = 0 at a rising edge SHALL force IDLE, out_valid = 0, result = 0, zero = 0, ovf = 0, err = 0, multiply counter = 0.
REQ-030 Reset overrides any state including mid-BUSY; aborted multiply produces no out_valid.
REQ-031 in_ready SHALL be 0 while rst_n = 0 and 1 on the first cycle after release.

Verification
REQ-032 WIDTH=32, aluop=10 funct=100000, a=5 b=7 -> next cycle out_valid=1, result=12, zero=0, ovf=0.
REQ-033 aluop=01, a=0x7FFFFFFF b=0xFFFFFFFF -> result=0x80000000, ovf=1; aluop=00 a=0x80000000 b=0x80000000 -> result=0, zero=1, ovf=1.
REQ-034 aluop=10 funct=011000, a=1234 b=5678 -> in_ready=0 for 32 cycles, out_valid on cycle 33, result=7006652; rst_n pulsed at cycle 10 instead -> no out_valid, IDLE.
REQ-035 funct=101010 a=0xFFFFFFFF b=1 -> result=1; funct=000011 a=0x80000000 b=4 -> result=0xF8000000; aluop=11 -> err=1, result=0.
REQ-036 out_ready held 0 for 3 cycles in DONE -> result stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same cycle, next result one cycle later.
REQ-037 Repeat REQ-032/034 with WIDTH=8, MULT_EN=0: mult funct -> err=1 at latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Single-issue ALU with an iterative shift-add multiplier; latency 1, or WIDTH+1 for mult.
// The result is held in DONE until out_ready. in_ready is low while busy, in reset, or stalled on output.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int MULT_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   localparam int            SW       = $clog2(WIDTH);
   localparam int            MSB      = WIDTH - 1;
   localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT,
      OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
   } op_t;

   state_t           state;
   state_t           state_nx;
   op_t              op;
   logic             accept;
   logic             last_iter;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic [SW-1:0]    cnt;

   always_comb begin
      op = OP_ILL;
      case (aluop)
         2'b00: op = OP_ADD;
         2'b01: op = OP_SUB;
         2'b10: begin
            case (funct)
               6'b100000: op = OP_ADD;
               6'b100010: op = OP_SUB;
               6'b100100: op = OP_AND;
               6'b100101: op = OP_OR;
               6'b100111: op = OP_NOR;
               6'b101010: op = OP_SLT;
               6'b000000: op = OP_SLL;
               6'b000010: op = OP_SRL;
               6'b000011: op = OP_SRA;
               6'b011000: op = (MULT_EN != 0) ? OP_MUL : OP_ILL;
               default:   op = OP_ILL;
            endcase
         end
         default: op = OP_ILL;
      endcase
   end

   assign sum   = a + b;
   assign diff  = a - b;
   assign shamt = b[SW-1:0];

   // Illegal ops and mult fall through to zero; mult writes its result from the BUSY path.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   assign last_iter = (cnt == CNT_LAST);

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         IDLE:    in_ready = rst_n;
         DONE:    in_ready = rst_n & out_ready;
         default: in_ready = 1'b0;
      endcase
      accept = in_valid & in_ready;
      case (state)
         IDLE: begin
            if (accept) state_nx = (op == OP_MUL) ? BUSY : DONE;
         end
         BUSY: begin
            if (last_iter) state_nx = DONE;
         end
         DONE: begin
            if (out_ready) begin
               if (accept) state_nx = (op == OP_MUL) ? BUSY : DONE;
               else        state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign out_valid = (state == DONE);
   assign acc_nx    = acc + (mplier[0] ? mcand : '0);

   // Outputs are only written on completion, so they hold across IDLE and BUSY.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
         err    <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (accept) begin
         if (op == OP_MUL) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
         end else begin
            result <= alu_res;
            zero   <= (alu_res == '0);
            ovf    <= alu_ovf;
            err    <= (op == OP_ILL);
         end
      end else if (state == BUSY) begin
         acc    <= acc_nx;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + SW'(1);
         if (last_iter) begin
            result <= acc_nx;
            zero   <= (acc_nx == '0);
            ovf    <= 1'b0;
            err    <= 1'b0;
         end
      end
   end

   a_busy_not_ready: assert property (@(posedge clk) (state == BUSY) |-> !in_ready);
   a_done_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(zero)
                                     && $stable(ovf) && $stable(err)));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table plus hand sequences for mult, reset abort and backpressure.
module tb_alu_exec_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, out_ready, in_ready, out_valid, zero, ovf, err;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] a, b, result;

   logic        in_valid8, out_ready8, in_ready8, out_valid8, zero8, ovf8, err8;
   logic [1:0]  aluop8;
   logic [5:0]  funct8;
   logic [7:0]  a8, b8, result8;

   alu_exec_unit #(.WIDTH(32), .MULT_EN(1)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .funct(funct), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .ovf(ovf), .err(err)
   );

   alu_exec_unit #(.WIDTH(8), .MULT_EN(0)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .aluop(aluop8), .funct(funct8), .a(a8), .b(b8),
      .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
      .zero(zero8), .ovf(ovf8), .err(err8)
   );

   typedef struct {
      string       name;
      logic [1:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        err;
   } vec_t;

   vec_t vecs[$];
   vec_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input string n, input logic [1:0] op, input logic [5:0] f,
                               input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
                               input logic z, input logic o, input logic e);
      vec_t v;
      v.name = n; v.aluop = op; v.funct = f; v.a = x; v.b = y;
      v.res = r; v.zero = z; v.ovf = o; v.err = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic issue(input vec_t v);
      @(negedge clk);
      chk({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; aluop = v.aluop; funct = v.funct; a = v.a; b = v.b; out_ready = 1'b1;
      @(posedge clk);
      sbq.push_back(v);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for out_valid, pops the oldest expectation and checks it plus the extra wait.
   task automatic collect(input int budget, input int exp_wait);
      int   n = 0;
      vec_t v;
      while (!out_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty actual=out_valid with no pending op required=pending op");
         return;
      end
      v = sbq.pop_front();
      chk({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({v.name, ".result"},    result,         v.res);
      chk({v.name, ".zero"},      32'(zero),      32'(v.zero));
      chk({v.name, ".ovf"},       32'(ovf),       32'(v.ovf));
      chk({v.name, ".err"},       32'(err),       32'(v.err));
      chk({v.name, ".latency"},   32'(n),         32'(exp_wait));
   endtask

   task automatic op8(input string nm, input logic [1:0] op, input logic [5:0] f,
                      input logic [7:0] x, input logic [7:0] y, input logic [7:0] r,
                      input logic z, input logic o, input logic e);
      @(negedge clk);
      in_valid8 = 1'b1; aluop8 = op; funct8 = f; a8 = x; b8 = y; out_ready8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      chk({nm, ".out_valid"}, 32'(out_valid8), 32'd1);
      chk({nm, ".result"},    32'(result8),    32'(r));
      chk({nm, ".zero"},      32'(zero8),      32'(z));
      chk({nm, ".ovf"},       32'(ovf8),       32'(o));
      chk({nm, ".err"},       32'(err8),       32'(e));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic        seen;
      logic [31:0] ra, rb;

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; aluop = '0; funct = '0; a = '0; b = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; aluop8 = '0; funct8 = '0; a8 = '0; b8 = '0;

      vecs.push_back(mk("add_5_7",      2'b10, 6'b100000, 32'd5,          32'd7,          32'd12,         0, 0, 0));
      vecs.push_back(mk("sub_ovf",      2'b01, 6'b000000, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000,  0, 1, 0));
      vecs.push_back(mk("add_ovf_zero", 2'b00, 6'b000000, 32'h8000_0000,  32'h8000_0000,  32'h0,          1, 1, 0));
      vecs.push_back(mk("slt_neg",      2'b10, 6'b101010, 32'hFFFF_FFFF,  32'd1,          32'd1,          0, 0, 0));
      vecs.push_back(mk("slt_pos",      2'b10, 6'b101010, 32'd1,          32'hFFFF_FFFF,  32'd0,          1, 0, 0));
      vecs.push_back(mk("sra_4",        2'b10, 6'b000011, 32'h8000_0000,  32'd4,          32'hF800_0000,  0, 0, 0));
      vecs.push_back(mk("sra_0",        2'b10, 6'b000011, 32'h8000_0001,  32'd32,         32'h8000_0001,  0, 0, 0));
      vecs.push_back(mk("aluop_11",     2'b11, 6'b100000, 32'd5,          32'd5,          32'd0,          1, 0, 1));
      vecs.push_back(mk("funct_bad",    2'b10, 6'b111111, 32'd9,          32'd3,          32'd0,          1, 0, 1));
      vecs.push_back(mk("and",          2'b10, 6'b100100, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  0, 0, 0));
      vecs.push_back(mk("or",           2'b10, 6'b100101, 32'hF000_0000,  32'h0000_000F,  32'hF000_000F,  0, 0, 0));
      vecs.push_back(mk("nor",          2'b10, 6'b100111, 32'd0,          32'd0,          32'hFFFF_FFFF,  0, 0, 0));
      vecs.push_back(mk("sll_mask",     2'b10, 6'b000000, 32'd1,          32'h0000_0023,  32'd8,          0, 0, 0));
      vecs.push_back(mk("srl_31",       2'b10, 6'b000010, 32'h8000_0000,  32'd31,         32'd1,          0, 0, 0));
      vecs.push_back(mk("srl_4",        2'b10, 6'b000010, 32'hF000_0000,  32'd4,          32'h0F00_0000,  0, 0, 0));
      vecs.push_back(mk("sub_eq",       2'b10, 6'b100010, 32'd5,          32'd5,          32'd0,          1, 0, 0));
      vecs.push_back(mk("add_f_ovf",    2'b10, 6'b100000, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  0, 1, 0));
      vecs.push_back(mk("sub_f_ovf",    2'b10, 6'b100010, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  0, 1, 0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.in_ready",  32'(in_ready),  32'd0);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.result",    result,         32'd0);
      chk("reset.zero",      32'(zero),      32'd0);
      chk("reset.ovf",       32'(ovf),       32'd0);
      chk("reset.err",       32'(err),       32'd0);
      chk("reset.in_ready8", 32'(in_ready8), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("release.in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         issue(vecs[i]);
         collect(5, 0);
      end

      // Multiply: in_valid held high and out_ready low while busy must both be ignored.
      @(negedge clk);
      in_valid = 1'b1; aluop = 2'b10; funct = 6'b011000; a = 32'd1234; b = 32'd5678; out_ready = 1'b1;
      @(posedge clk);
      sbq.push_back(mk("mult_1234x5678", 2'b10, 6'b011000, 32'd1234, 32'd5678, 32'd7006652, 0, 0, 0));
      @(negedge clk);
      funct = 6'b100000; a = 32'd1; b = 32'd1; out_ready = 1'b0;
      n = 0; seen = 1'b0;
      while (!out_valid && n < 100) begin
         if (in_ready) seen = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("mult.busy_cycles",   32'(n),        32'd32);
      chk("mult.in_ready_busy", 32'(seen),     32'd0);
      chk("mult.in_ready_done", 32'(in_ready), 32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      collect(2, 0);

      // Reset in the middle of a multiply.
      @(negedge clk);
      in_valid = 1'b1; aluop = 2'b10; funct = 6'b011000; a = 32'd1234; b = 32'd5678; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid.in_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid.result",    result,         32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_mid.in_ready_release", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("rst_mid.no_out_valid", 32'(seen), 32'd0);

      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         issue(mk("mult_rnd", 2'b10, 6'b011000, ra, rb, ra * rb, (ra * rb) == 32'd0, 0, 0));
         collect(100, 32);
      end

      // Backpressure in DONE, then retire and accept in the same cycle.
      @(negedge clk);
      in_valid = 1'b1; aluop = 2'b00; funct = '0; a = 32'd3; b = 32'd4; out_ready = 1'b0;
      @(posedge clk);
      sbq.push_back(mk("bp_first", 2'b00, 6'b000000, 32'd3, 32'd4, 32'd7, 0, 0, 0));
      @(negedge clk);
      aluop = 2'b01; a = 32'd10; b = 32'd2;
      for (int i = 0; i < 3; i++) begin
         chk("bp.out_valid",    32'(out_valid), 32'd1);
         chk("bp.result_hold",  result,         32'd7);
         chk("bp.in_ready_low", 32'(in_ready),  32'd0);
         @(negedge clk);
      end
      collect(1, 0);
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_release", 32'(in_ready), 32'd1);
      @(posedge clk);
      sbq.push_back(mk("bp_second", 2'b01, 6'b000000, 32'd10, 32'd2, 32'd8, 0, 0, 0));
      @(negedge clk);
      in_valid = 1'b0;
      collect(1, 0);

      op8("w8_add",      2'b10, 6'b100000, 8'd5,   8'd7,   8'd12,  0, 0, 0);
      op8("w8_mult_ill", 2'b10, 6'b011000, 8'd12,  8'd34,  8'd0,   1, 0, 1);
      op8("w8_sub_ovf",  2'b01, 6'b000000, 8'h7F,  8'hFF,  8'h80,  0, 1, 0);
      op8("w8_sub_ovf2", 2'b01, 6'b000000, 8'h80,  8'h01,  8'h7F,  0, 1, 0);
      op8("w8_sra",      2'b10, 6'b000011, 8'h80,  8'd4,   8'hF8,  0, 0, 0);
      op8("w8_sll_mask", 2'b10, 6'b000000, 8'd1,   8'h0B,  8'd8,   0, 0, 0);

      @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
